// File: rtl/hilo_mult_seq.sv
// Sequencing stage for the 32x32 array multipliers: registers the operands, waits
// out the ripple settle time, then loads the selected product into HI/LO.
module hilo_mult_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [DATA_WIDTH-1:0] OP_A,
  input  logic [DATA_WIDTH-1:0] OP_B,
  input  logic                  MTHI,
  input  logic                  MTLO,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic [DATA_WIDTH-1:0] MCND,
  output logic [DATA_WIDTH-1:0] MPLR,
  input  logic [DATA_WIDTH-1:0] PROD_S_HI,
  input  logic [DATA_WIDTH-1:0] PROD_S_LO,
  input  logic [DATA_WIDTH-1:0] PROD_U_HI,
  input  logic [DATA_WIDTH-1:0] PROD_U_LO,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    sign_reg, sign_next;
  logic [DATA_WIDTH-1:0]   mcnd_reg, mcnd_next;
  logic [DATA_WIDTH-1:0]   mplr_reg, mplr_next;
  logic [DATA_WIDTH-1:0]   hi_reg, hi_next;
  logic [DATA_WIDTH-1:0]   lo_reg, lo_next;
  logic [DATA_WIDTH-1:0]   sel_hi, sel_lo;

  // Product pair chosen by the sign captured with START, not the live SIGNED pin.
  assign sel_hi = sign_reg ? PROD_S_HI : PROD_U_HI;
  assign sel_lo = sign_reg ? PROD_S_LO : PROD_U_LO;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      mcnd_reg  <= '0;
      mplr_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sign_reg  <= sign_next;
      mcnd_reg  <= mcnd_next;
      mplr_reg  <= mplr_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sign_next  = sign_reg;
    mcnd_next  = mcnd_reg;
    mplr_next  = mplr_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (START) begin
          // A same-cycle move-to is dropped so HI/LO stay untouched until capture.
          mcnd_next  = OP_A;
          mplr_next  = OP_B;
          sign_next  = SIGNED;
          cnt_next   = SETTLE_INIT;
          state_next = S_SETTLE;
        end else begin
          if (MTHI) hi_next = WDATA;
          if (MTLO) lo_next = WDATA;
        end
      end
      S_SETTLE: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          hi_next    = sel_hi;
          lo_next    = sel_lo;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign MCND = mcnd_reg;
  assign MPLR = mplr_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign BUSY = (state_reg == S_SETTLE);
  assign DONE = (state_reg == S_DONE);

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Scoreboarded bench for hilo_mult_seq with a stand-in array multiplier.
module tb_hilo_mult_seq;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sgn = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, wdata = '0;
  logic [31:0] mcnd, mplr, hi, lo;
  logic [31:0] ps_hi, ps_lo, pu_hi, pu_lo;
  logic        busy, done;

  hilo_mult_seq #(.SETTLE_CYCLES(S), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .OP_A(op_a), .OP_B(op_b),
    .MTHI(mthi), .MTLO(mtlo), .WDATA(wdata), .MCND(mcnd), .MPLR(mplr),
    .PROD_S_HI(ps_hi), .PROD_S_LO(ps_lo), .PROD_U_HI(pu_hi), .PROD_U_LO(pu_lo),
    .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Stand-in for the signed and unsigned array multipliers.
  logic signed [63:0] ext_a, ext_b;
  logic [63:0] prod_s, prod_u;
  assign ext_a  = {{32{mcnd[31]}}, mcnd};
  assign ext_b  = {{32{mplr[31]}}, mplr};
  assign prod_s = ext_a * ext_b;
  assign prod_u = {32'b0, mcnd} * {32'b0, mplr};
  assign {ps_hi, ps_lo} = prod_s;
  assign {pu_hi, pu_lo} = prod_u;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Mathematical 64-bit product of two 32-bit operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Monitor: every DONE must match the oldest outstanding multiply, on time.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got DONE=1 expected no pending multiply (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {hi, lo}, e.prod);
        chk("capture_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  logic [31:0] hi_m = '0, lo_m = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic with_mt);
    exp_t e;
    start = 1'b1; op_a = a; op_b = b; sgn = s;
    mtlo = with_mt; wdata = 32'hDEADBEEF;
    tick();
    e.prod = ref_prod(a, b, s);
    e.at   = cyc + S;
    sb.push_back(e);
    {hi_m, lo_m} = e.prod;
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    op_a = $urandom; op_b = $urandom; sgn = $urandom_range(0, 1);
  endtask

  // Returns at the negedge where DONE is seen; an expired budget is a failure.
  task automatic wait_done;
    for (int i = 0; i < S + 8; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total_cnt++;
    $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", S + 8);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("reset_state", {hi, lo, mcnd, mplr, 30'b0, busy, done}, '0);
    #2 rst = 1'b0;
    tick();

    // 3*5 unsigned with BUSY/DONE window
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < S; i++) begin
      @(negedge clk);
      chk("busy_window", {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk("done_pulse", {busy, done}, 2'b01);
    chk("p3x5", {hi, lo}, 64'h00000000_0000000F);
    @(negedge clk);
    chk("done_once", {busy, done}, 2'b00);

    issue(32'hFFFFFFFD, 32'h5, 1'b1, 1'b0); wait_done();
    chk("s_neg3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(32'hFFFFFFFD, 32'h5, 1'b0, 1'b0); wait_done();
    chk("u_neg3x5", {hi, lo}, 64'h00000004_FFFFFFF1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0); wait_done();
    chk("u_max_sq", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(32'h80000000, 32'h80000000, 1'b1, 1'b0); wait_done();
    chk("s_min_sq", {hi, lo}, 64'h40000000_00000000);

    // START and MTHI while busy are ignored
    issue(32'h1234, 32'h10, 1'b0, 1'b0);
    start = 1'b1; op_a = 32'd7; mthi = 1'b1; wdata = 32'h12345678;
    tick();
    start = 1'b0; mthi = 1'b0;
    @(negedge clk);
    chk("busy_mcnd_hold", 64'(mcnd), 64'h1234);
    chk("busy_mthi_drop", 64'(hi), 64'h40000000);
    wait_done();
    chk("busy_capture", {hi, lo}, 64'h00000000_00012340);
    repeat (S + 2) tick();

    // Move-to both in idle
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);

    // START with MTLO: move-to dropped
    issue(32'd2, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    chk("start_mt_drop", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);
    wait_done();
    chk("start_mt_capture", {hi, lo}, 64'h6);

    // Back-to-back START during DONE
    issue(32'd9, 32'd9, 1'b0, 1'b0);
    wait_done();
    issue(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_busy", {busy, done}, 2'b10);
    wait_done();

    // Randomised multiplies interleaved with idle move-to writes
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        mthi = $urandom_range(0, 1); mtlo = $urandom_range(0, 1); wdata = $urandom;
        if (mthi) hi_m = wdata;
        if (mtlo) lo_m = wdata;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("rand_mt", {hi, lo}, {hi_m, lo_m});
      end
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      wait_done();
      if ($urandom_range(0, 1) == 0) tick();
    end

    // Asynchronous reset mid-settle aborts the multiply
    repeat (2) tick();
    issue(32'h55, 32'h66, 1'b1, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {hi, lo, mcnd, mplr, 30'b0, busy, done}, '0);
    sb.delete();
    tick();
    #3 rst = 1'b0;
    begin
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < 2 * S + 4; i++) begin
        @(negedge clk);
        if (done || busy) saw = 1'b1;
      end
      chk("no_done_after_reset", 64'(saw), 64'b0);
      chk("idle_after_reset", {hi, lo}, 64'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/hilo_mult_seq.md
Name: hilo_mult_seq

Overview:
- Sequencing stage around the 32x32 array multipliers (signed MULT32, unsigned MULT32_U).
- Registers the operands that drive the multiplier inputs and waits a fixed number of settle cycles, because the combinational ripple-carry array is a multicycle path.
- Captures the selected product into architectural HI/LO registers.
- Also services move-to-HI/LO writes. Its outputs feed the ALU result mux for MFHI/MFLO.

Parameters:
- SETTLE_CYCLES, 4, clock edges between operand capture and product capture; legal range 1..15.
- DATA_WIDTH, 32, operand and HI/LO width; fixed at 32.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  request a multiply this cycle.
- SIGNED  in  1  sampled with START; 1 selects the signed product, 0 selects the unsigned product.
- OP_A  in  32  multiplicand, sampled with START.
- OP_B  in  32  multiplier, sampled with START.
- MTHI  in  1  write WDATA into HI.
- MTLO  in  1  write WDATA into LO.
- WDATA  in  32  move-to data.
- MCND  out  32  registered multiplicand; drives A of both multipliers.
- MPLR  out  32  registered multiplier; drives B of both multipliers.
- PROD_S_HI  in  32  HI output of the signed multiplier.
- PROD_S_LO  in  32  LO output of the signed multiplier.
- PROD_U_HI  in  32  HI output of the unsigned multiplier.
- PROD_U_LO  in  32  LO output of the unsigned multiplier.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- BUSY  out  1  multiply in flight.
- DONE  out  1  one-cycle pulse: HI/LO were just loaded with a product.

Behaviour:
- Reset (async, RST=1): state IDLE; MCND, MPLR, HI, LO = 0; counter = 0; sign select = 0; BUSY = 0; DONE = 0. Reset asserted mid-multiply aborts the operation; no product is ever written.
- States:
  - IDLE: accepts START or move-to writes.
  - SETTLE: waits for the array to settle.
  - DONE: one cycle; behaves exactly as IDLE for START and move-to inputs.
- IDLE or DONE with START=1 at edge t0:
  - MCND<=OP_A, MPLR<=OP_B, sign select<=SIGNED, counter<=SETTLE_CYCLES, next state SETTLE.
- SETTLE, at each edge:
  - counter decrements.
  - On the edge where counter==1: HI/LO <= the selected product pair; next state DONE.
  - Product capture therefore occurs at edge t0+SETTLE_CYCLES.
- BUSY = 1 exactly while in SETTLE, i.e. from after t0 until the capture edge. DONE = 1 exactly while in DONE. Both are decoded from registered state only.
- MCND/MPLR hold their values until the next accepted START, so multiplier inputs stay stable throughout SETTLE.
- START while BUSY: ignored, no queueing, no error flag.
- MTHI/MTLO in IDLE/DONE: write WDATA into HI and/or LO at the edge. Both asserted writes WDATA into both registers.
- MTHI/MTLO while BUSY: ignored; the product capture wins.
- START together with MTHI/MTLO in the same IDLE/DONE cycle: START accepted, move-to dropped, HI/LO unchanged until product capture.
- DONE state goes to IDLE at the next edge unless START was sampled, in which case it goes to SETTLE (back-to-back multiplies; one idle-free cycle between captures).
- No arithmetic in this block: products are passed through unmodified, 64-bit result = {HI, LO}.
- X-safety: a product input carrying X/Z at the capture edge is a bench failure. HI/LO must never be loaded outside the capture edge.

Test Plan:
- Reset, then START SIGNED=0 with 3 and 5, SETTLE_CYCLES=4 -> BUSY high 4 cycles; DONE pulses once; HI=0x00000000, LO=0x0000000F.
- START SIGNED=1 with 0xFFFFFFFD and 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Same operands with SIGNED=0 -> HI=0x00000004, LO=0xFFFFFFF1.
- SIGNED=0 with 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. SIGNED=1 with 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
- While BUSY: pulse START (OP_A=7) and MTHI (WDATA=0x12345678) -> both ignored; MCND unchanged; the original product is captured.
- In IDLE:
  - MTHI=1, MTLO=1 with WDATA=0xA5A5A5A5 -> HI=LO=0xA5A5A5A5.
  - Next, START with MTLO in the same cycle -> LO unchanged until capture.
  - Then START asserted during the DONE cycle -> a new SETTLE begins with no IDLE cycle.
- Assert RST asynchronously two cycles into SETTLE -> HI, LO, MCND, MPLR, BUSY, DONE go to 0 immediately; no DONE pulse follows after RST is released.
